motor_encoder: RTL and testbench

Quadrature encoder receiver for the DC motor that the PWM block drives. It filters and decodes the encoder A/B channels into a signed position count, the feedback direction, a per-window speed count and a stall flag. The state machine uses these outputs to confirm the motor moved after the PWM was enabled, closing the loop on the open-loop PWM output.

---
 rtl/motor_encoder.sv | 121 ++++++++++++
 tb/tb_motor_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_encoder.sv
// Quadrature encoder receiver: sync + glitch filter + x4 decode, speed window, stall detect.
// Latency: stable A/B change to position update is FILT+3 sclk cycles; speed updates once per window.
// Backpressure: none; free-running sensor input, outputs are levels or one-cycle pulses.
module motor_encoder #(
    parameter int POS_W     = 16,
    parameter int SPD_W     = 12,
    parameter int WIN_CYC   = 50000,
    parameter int FILT      = 3,
    parameter int STALL_WIN = 8
) (
    input  logic                    sclk,
    input  logic                    s_rst_n,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    enable,
    input  logic                    clr,
    output logic signed [POS_W-1:0] position,
    output logic                    dir_fb,
    output logic [SPD_W-1:0]        speed,
    output logic                    spd_valid,
    output logic                    stall,
    output logic                    err
);

    localparam int          WIN_W   = $clog2(WIN_CYC + 1);
    localparam int          ST_W    = $clog2(STALL_WIN + 1);
    localparam logic [3:0]  FILT_M1 = 4'(FILT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [SPD_W-1:0] SPD_MAX  = {SPD_W{1'b1}};
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STALL_WIN);

    // Channel index 1 = A, 0 = B
    logic [1:0]       sync1, sync2, filt, prev;
    logic [3:0]       fcnt [2];
    logic [WIN_W-1:0] win_cnt;
    logic [SPD_W-1:0] edge_cnt;
    logic [ST_W-1:0]  st_cnt;

    logic chg_a, chg_b, step, illegal, fwd, win_end;
    logic [SPD_W-1:0] edge_sum;

    assign chg_a    = prev[1] ^ filt[1];
    assign chg_b    = prev[0] ^ filt[0];
    assign step     = chg_a ^ chg_b;
    assign illegal  = chg_a & chg_b;
    // For a single-bit Gray change, forward iff old A differs from new B
    assign fwd      = prev[1] ^ filt[0];
    assign win_end  = (win_cnt == WIN_LAST);
    assign edge_sum = (edge_cnt == SPD_MAX) ? SPD_MAX : edge_cnt + SPD_W'(step);
    assign stall    = enable && (st_cnt == ST_MAX);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (fcnt[i] == FILT_M1) begin
                        filt[i] <= sync2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 4'd1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            prev     <= '0;
            position <= '0;
            dir_fb   <= 1'b0;
            err      <= 1'b0;
        end else begin
            prev <= filt;
            err  <= illegal;
            if (step)
                dir_fb <= fwd;
            if (clr)
                position <= '0;
            else if (step)
                position <= fwd ? position + POS_W'(1) : position - POS_W'(1);
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            win_cnt   <= '0;
            edge_cnt  <= '0;
            speed     <= '0;
            spd_valid <= 1'b0;
            st_cnt    <= '0;
        end else begin
            spd_valid <= win_end;
            if (win_end) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
                speed    <= edge_sum;
            end else begin
                win_cnt  <= win_cnt + WIN_W'(1);
                edge_cnt <= edge_sum;
            end

            if (!enable || step)
                st_cnt <= '0;
            else if (win_end)
                st_cnt <= (edge_sum != '0) ? '0 :
                          (st_cnt == ST_MAX) ? ST_MAX : st_cnt + ST_W'(1);
        end
    end

endmodule

// File: tb/tb_motor_encoder.sv
module tb_motor_encoder;

    localparam int FILT = 3;
    localparam int WIN  = 1000;

    logic        sclk = 1'b0;
    logic        s_rst_n, enc_a, enc_b, enable, clr;
    logic signed [15:0] position;
    logic        dir_fb, spd_valid, stall, err;
    logic [11:0] speed;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    logic [15:0] exp_pos;
    logic [1:0]  st;

    motor_encoder #(.POS_W(16), .SPD_W(12), .WIN_CYC(WIN), .FILT(FILT), .STALL_WIN(8)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .enable(enable), .clr(clr), .position(position), .dir_fb(dir_fb),
        .speed(speed), .spd_valid(spd_valid), .stall(stall), .err(err)
    );

    always #5 sclk = ~sclk;

    always @(negedge sclk) if (err) err_cnt++;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    function automatic logic [1:0] nxt(input logic [1:0] s, input bit f);
        case (s)
            2'b00:   return f ? 2'b01 : 2'b10;
            2'b01:   return f ? 2'b11 : 2'b00;
            2'b11:   return f ? 2'b10 : 2'b01;
            default: return f ? 2'b00 : 2'b11;
        endcase
    endfunction

    // One Gray step; optionally checks the exact FILT+3 update latency
    task automatic step(input bit f, input int hold, input bit chk);
        logic [15:0] old_pos;
        old_pos = exp_pos;
        st = nxt(st, f);
        exp_pos = f ? exp_pos + 16'd1 : exp_pos - 16'd1;
        tick();
        {enc_a, enc_b} = st;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (chk && i == FILT + 2) begin
                tests++;
                if (position !== old_pos) begin
                    fails++;
                    $display("FAIL early_update pos=%h expected %h", position, old_pos);
                end
            end
            if (chk && i == FILT + 3) begin
                tests++;
                if (position !== exp_pos || dir_fb !== f) begin
                    fails++;
                    $display("FAIL step_update pos=%h dir=%b expected %h dir=%b", position, dir_fb, exp_pos, f);
                end
            end
        end
    endtask

    task automatic wait_spd();
        bit seen;
        seen = 0;
        for (int i = 0; i < WIN + 100 && !seen; i++) begin
            tick();
            if (spd_valid) seen = 1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL spd_valid_timeout spd_valid=0 expected 1");
        end
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; enable = 1'b0; clr = 1'b0;
        st = 2'b00; exp_pos = 16'd0;
        repeat (3) tick();
        tests++;
        if (position !== 16'd0 || dir_fb !== 1'b0 || speed !== 12'd0 ||
            spd_valid !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs pos=%h dir=%b spd=%h vld=%b stall=%b err=%b expected all 0",
                     position, dir_fb, speed, spd_valid, stall, err);
        end
        s_rst_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_forward();
        int e0;
        e0 = err_cnt;
        for (int k = 0; k < 8; k++) step(1'b1, 20, 1'b1);
        tests++;
        if (position !== 16'd8 || dir_fb !== 1'b1) begin
            fails++;
            $display("FAIL forward_final pos=%h dir=%b expected 0008 dir=1", position, dir_fb);
        end
        tests++;
        if (err_cnt != e0) begin
            fails++;
            $display("FAIL forward_err err_pulses=%0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_reverse_wrap();
        tick(); clr = 1'b1;
        tick(); clr = 1'b0;
        exp_pos = 16'd0;
        tests++;
        if (position !== 16'd0) begin
            fails++;
            $display("FAIL clr_pos pos=%h expected 0000", position);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 20, 1'b0);
        tests++;
        if (position !== 16'hFFFD || dir_fb !== 1'b0) begin
            fails++;
            $display("FAIL reverse_wrap pos=%h dir=%b expected fffd dir=0", position, dir_fb);
        end
        for (int k = 0; k < 3; k++) step(1'b1, 20, 1'b0);
        tests++;
        if (position !== 16'd0 || dir_fb !== 1'b1) begin
            fails++;
            $display("FAIL forward_back pos=%h dir=%b expected 0000 dir=1", position, dir_fb);
        end
    endtask

    task automatic test_glitch();
        int e0;
        e0 = err_cnt;
        tick(); enc_a = 1'b1;
        repeat (2) tick();
        enc_a = 1'b0;
        repeat (15) tick();
        tests++;
        if (position !== exp_pos || err_cnt != e0) begin
            fails++;
            $display("FAIL glitch_2cyc pos=%h err_pulses=%0d expected %h and 0", position, err_cnt - e0, exp_pos);
        end
        tick(); enc_a = 1'b1;
        repeat (3) tick();
        enc_a = 1'b0;
        repeat (3) tick();
        tests++;
        if (position !== exp_pos - 16'd1 || dir_fb !== 1'b0) begin
            fails++;
            $display("FAIL glitch_3cyc_rise pos=%h dir=%b expected %h dir=0", position, dir_fb, exp_pos - 16'd1);
        end
        repeat (3) tick();
        tests++;
        if (position !== exp_pos || dir_fb !== 1'b1) begin
            fails++;
            $display("FAIL glitch_3cyc_fall pos=%h dir=%b expected %h dir=1", position, dir_fb, exp_pos);
        end
        repeat (10) tick();
    endtask

    task automatic test_illegal();
        int e0;
        e0 = err_cnt;
        tick(); enc_a = 1'b1; enc_b = 1'b1;
        st = 2'b11;
        repeat (5) tick();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL illegal_early err=%b expected 0", err);
        end
        tick();
        tests++;
        if (err !== 1'b1 || position !== exp_pos) begin
            fails++;
            $display("FAIL illegal_pulse err=%b pos=%h expected 1 and %h", err, position, exp_pos);
        end
        tick();
        tests++;
        if (err !== 1'b0 || err_cnt != e0 + 1) begin
            fails++;
            $display("FAIL illegal_width err=%b pulses=%0d expected 0 and 1", err, err_cnt - e0);
        end
        step(1'b1, 20, 1'b1);
    endtask

    task automatic test_clr_edge();
        step(1'b0, 20, 1'b0);
        st = nxt(st, 1'b1);
        tick(); {enc_a, enc_b} = st;
        repeat (5) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_pos = 16'd0;
        tests++;
        if (position !== 16'd0 || dir_fb !== 1'b1) begin
            fails++;
            $display("FAIL clr_with_edge pos=%h dir=%b expected 0000 dir=1", position, dir_fb);
        end
        repeat (10) tick();
    endtask

    task automatic test_speed();
        wait_spd();
        for (int k = 0; k < 100; k++) step(1'b1, 5, 1'b0);
        wait_spd();
        tests++;
        if (speed !== 12'd100) begin
            fails++;
            $display("FAIL speed_100 speed=%0d expected 100", speed);
        end
        tick();
        tests++;
        if (spd_valid !== 1'b0) begin
            fails++;
            $display("FAIL spd_valid_width spd_valid=%b expected 0", spd_valid);
        end
        wait_spd();
        tests++;
        if (speed !== 12'd0) begin
            fails++;
            $display("FAIL speed_idle speed=%0d expected 0", speed);
        end
    endtask

    task automatic test_stall();
        enable = 1'b1;
        for (int w = 1; w <= 8; w++) begin
            wait_spd();
            if (w == 7) begin
                tests++;
                if (stall !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_early stall=%b expected 0", stall);
                end
            end
        end
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL stall_set stall=%b expected 1", stall);
        end
        step(1'b1, 6, 1'b0);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL stall_edge_clear stall=%b expected 0", stall);
        end
        repeat (9) wait_spd();
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL stall_reset stall=%b expected 1", stall);
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL stall_enable_clear stall=%b expected 0", stall);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        step(1'b1, 20, 1'b0);
        repeat (300) tick();
        #2;
        s_rst_n = 1'b0;
        enc_a = 1'b0; enc_b = 1'b1;
        #1;
        tests++;
        if (position !== 16'd0 || dir_fb !== 1'b0 || speed !== 12'd0 ||
            spd_valid !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid pos=%h dir=%b spd=%h vld=%b stall=%b err=%b expected all 0",
                     position, dir_fb, speed, spd_valid, stall, err);
        end
        repeat (2) tick();
        s_rst_n = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < WIN + 100) begin
            tick();
            n++;
            if (n == 20) begin
                tests++;
                if (position !== 16'd1 || dir_fb !== 1'b1) begin
                    fails++;
                    $display("FAIL reset_nonzero_start pos=%h dir=%b expected 0001 dir=1", position, dir_fb);
                end
            end
            if (spd_valid) seen = 1;
        end
        tests++;
        if (n != WIN) begin
            fails++;
            $display("FAIL first_window cycles=%0d expected %0d", n, WIN);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_glitch();
        test_illegal();
        test_clr_edge();
        test_speed();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
